// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, link register and write-back entry type
package cpu_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0]  rw;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of write-back entries with registered count
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gpr_writeback.sv
// rtl/gpr_writeback.sv - GPR write-port arbiter for ALU and load results with pending scoreboard
module gpr_writeback
    import cpu_pkg::*;
#(
    parameter int               DEPTH    = 2,
    parameter logic [REG_W-1:0] LINK_REG = cpu_pkg::LINK_REG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_Rt,
    input  logic [REG_W-1:0]  alu_Rd,
    input  logic              alu_Rdst,
    input  logic              alu_jal,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_Rw,
    input  logic              ld_valid,
    input  logic [REG_W-1:0]  ld_Rw,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [REG_W-1:0]  hz_Rs,
    input  logic [REG_W-1:0]  hz_Rt,
    input  logic [REG_W-1:0]  hz_Rd,
    output logic              hazard,
    output logic              regWr,
    output logic [REG_W-1:0]  Rw,
    output logic [DATA_W-1:0] busW,
    output logic [NUM_REGS-1:0] pending
);

    logic                reg_wr_q, reg_wr_d;
    logic [REG_W-1:0]    rw_q, rw_d;
    logic [DATA_W-1:0]   bus_w_q, bus_w_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic [REG_W-1:0]    alu_dst;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t           fifo_head, ld_entry;

    assign ld_entry  = '{rw: ld_Rw, data: ld_data};
    assign ld_ready  = reset_n && !fifo_full;
    assign fifo_push = ld_valid && ld_ready;
    // ALU results own the port; the FIFO head only drains on ALU-idle cycles.
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (fifo_push),
        .push_entry_i (ld_entry),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        if (alu_jal)       alu_dst = LINK_REG;
        else if (alu_Rdst) alu_dst = alu_Rd;
        else               alu_dst = alu_Rt;
    end

    always_comb begin
        reg_wr_d = 1'b0;
        rw_d     = rw_q;
        bus_w_d  = bus_w_q;
        if (alu_valid) begin
            reg_wr_d = (alu_dst != '0);
            rw_d     = alu_dst;
            bus_w_d  = alu_data;
        end else if (fifo_pop) begin
            reg_wr_d = (fifo_head.rw != '0);
            rw_d     = fifo_head.rw;
            bus_w_d  = fifo_head.data;
        end
    end

    // Set beats clear so a re-issue in the retire cycle keeps the register pending.
    always_comb begin
        set_mask  = iss_valid ? (NUM_REGS'(1) << iss_Rw) : '0;
        clr_mask  = fifo_pop ? (NUM_REGS'(1) << fifo_head.rw) : '0;
        pending_d = ((pending_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_wr_q  <= 1'b0;
            rw_q      <= '0;
            bus_w_q   <= '0;
            pending_q <= '0;
        end else begin
            reg_wr_q  <= reg_wr_d;
            rw_q      <= rw_d;
            bus_w_q   <= bus_w_d;
            pending_q <= pending_d;
        end
    end

    assign regWr   = reg_wr_q;
    assign Rw      = rw_q;
    assign busW    = bus_w_q;
    assign pending = pending_q;
    assign hazard  = pending_q[hz_Rs] | pending_q[hz_Rt] | pending_q[hz_Rd];

endmodule

// File: tb/tb_gpr_writeback.sv
// tb/tb_gpr_writeback.sv - directed self-checking bench for gpr_writeback
module tb_gpr_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_Rdst, alu_jal;
    logic [4:0]  alu_Rt, alu_Rd;
    logic [31:0] alu_data;
    logic        iss_valid;
    logic [4:0]  iss_Rw;
    logic        ld_valid;
    logic [4:0]  ld_Rw;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  hz_Rs, hz_Rt, hz_Rd;
    logic        hazard;
    logic        regWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    gpr_writeback #(.DEPTH(2), .LINK_REG(5'd31)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_Rt(alu_Rt), .alu_Rd(alu_Rd),
        .alu_Rdst(alu_Rdst), .alu_jal(alu_jal), .alu_data(alu_data),
        .iss_valid(iss_valid), .iss_Rw(iss_Rw),
        .ld_valid(ld_valid), .ld_Rw(ld_Rw), .ld_data(ld_data), .ld_ready(ld_ready),
        .hz_Rs(hz_Rs), .hz_Rt(hz_Rt), .hz_Rd(hz_Rd), .hazard(hazard),
        .regWr(regWr), .Rw(Rw), .busW(busW), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jal;
        logic        rdst;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_wr;
        logic [4:0]  exp_rw;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        alu_valid = 0; alu_Rdst = 0; alu_jal = 0; alu_Rt = 0; alu_Rd = 0; alu_data = 0;
        iss_valid = 0; iss_Rw = 0;
        ld_valid = 0; ld_Rw = 0; ld_data = 0;
        hz_Rs = 0; hz_Rt = 0; hz_Rd = 0;
    endtask

    task automatic issue(input logic [4:0] r);
        iss_valid = 1; iss_Rw = r;
        tick();
        iss_valid = 0;
    endtask

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] data;
    } wr_t;

    initial begin
        wr_t obs [$];
        int  li;
        bit  acc;

        vecs[0] = '{1'b1, 1'b1, 5'd2, 5'd5, 32'h0000_1234, 1'b1, 5'd31};
        vecs[1] = '{1'b0, 1'b1, 5'd2, 5'd5, 32'h0000_BEEF, 1'b1, 5'd5};
        vecs[2] = '{1'b0, 1'b0, 5'd2, 5'd5, 32'h0000_CAFE, 1'b1, 5'd2};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 5'd9, 32'h0000_0055, 1'b0, 5'd0};
        vecs[4] = '{1'b0, 1'b1, 5'd9, 5'd0, 32'h0000_0066, 1'b0, 5'd0};
        vecs[5] = '{1'b1, 1'b0, 5'd0, 5'd0, 32'hDEAD_0001, 1'b1, 5'd31};

        clr_inputs();
        reset_n = 0;
        #12;
        chk("rst_regWr", {31'd0, regWr}, 0);
        chk("rst_ld_ready_low", {31'd0, ld_ready}, 0);
        chk("rst_pending", pending, 0);
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("post_rst_ld_ready", {31'd0, ld_ready}, 1);
        chk("post_rst_Rw_busW", {Rw, busW[26:0]}, 0);
        tick();

        // ALU destination resolution table
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_jal = vecs[i].jal; alu_Rdst = vecs[i].rdst;
            alu_Rt = vecs[i].rt; alu_Rd = vecs[i].rd; alu_data = vecs[i].data;
            tick();
            alu_valid = 0;
            chk($sformatf("vec%0d_regWr", i), {31'd0, regWr}, {31'd0, vecs[i].exp_wr});
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d_Rw", i), {27'd0, Rw}, {27'd0, vecs[i].exp_rw});
                chk($sformatf("vec%0d_busW", i), busW, vecs[i].data);
            end
            chk($sformatf("vec%0d_pending", i), pending, 0);
            tick();
            chk($sformatf("vec%0d_idle", i), {31'd0, regWr}, 0);
        end
        clr_inputs();

        // issue reg 7, then its load result retires two edges after acceptance
        issue(5'd7);
        chk("iss7_pending", pending, 32'h0000_0080);
        hz_Rs = 7;
        #1 chk("iss7_hazard_rs", {31'd0, hazard}, 1);
        hz_Rs = 0; hz_Rd = 7;
        #1 chk("iss7_hazard_rd", {31'd0, hazard}, 1);
        hz_Rd = 1; hz_Rt = 2;
        #1 chk("iss7_no_hazard", {31'd0, hazard}, 0);
        hz_Rt = 0; hz_Rs = 7;
        ld_valid = 1; ld_Rw = 7; ld_data = 32'hAA;
        tick();
        ld_valid = 0;
        chk("ld7_enq_regWr", {31'd0, regWr}, 0);
        chk("ld7_enq_pending", pending, 32'h0000_0080);
        tick();
        chk("ld7_regWr", {31'd0, regWr}, 1);
        chk("ld7_Rw", {27'd0, Rw}, 7);
        chk("ld7_busW", busW, 32'hAA);
        chk("ld7_pending", pending, 0);
        chk("ld7_hazard", {31'd0, hazard}, 0);
        clr_inputs();
        tick();

        // load for reg 3 held off by three ALU writes to reg 4
        issue(5'd3);
        alu_valid = 1; alu_Rdst = 1; alu_Rd = 4; alu_data = 32'h100;
        ld_valid = 1; ld_Rw = 3; ld_data = 32'h33;
        tick();
        ld_valid = 0;
        chk("stv0_Rw", {27'd0, Rw, regWr}, {27'd4, 1'b1});
        chk("stv0_busW", busW, 32'h100);
        alu_data = 32'h101;
        tick();
        chk("stv1_Rw", {27'd0, Rw, regWr}, {27'd4, 1'b1});
        chk("stv1_busW", busW, 32'h101);
        alu_data = 32'h102;
        tick();
        chk("stv2_Rw", {27'd0, Rw, regWr}, {27'd4, 1'b1});
        chk("stv2_busW", busW, 32'h102);
        chk("stv2_pending", pending, 32'h0000_0008);
        alu_valid = 0;
        tick();
        chk("stv_ld_Rw", {27'd0, Rw, regWr}, {27'd3, 1'b1});
        chk("stv_ld_busW", busW, 32'h33);
        chk("stv_ld_pending", pending, 0);
        tick();
        chk("stv_idle", {31'd0, regWr}, 0);
        clr_inputs();

        // FIFO full / backpressure / wrap over 3*DEPTH loads
        for (int r = 10; r < 16; r++) issue(5'(r));
        chk("wrap_pending_set", pending, 32'h0000_FC00);
        li = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            alu_valid = (cyc < 4); alu_Rdst = 1; alu_Rd = 4; alu_data = 32'h400 + cyc;
            ld_valid = (li < 6); ld_Rw = 5'(10 + li); ld_data = 32'hA0 + li;
            #1;
            if (cyc == 0) chk("wrap_ready_c0", {31'd0, ld_ready}, 1);
            if (cyc == 2) chk("wrap_full_c2", {31'd0, ld_ready}, 0);
            if (cyc == 3) chk("wrap_full_c3", {31'd0, ld_ready}, 0);
            acc = ld_valid && ld_ready;
            tick();
            if (acc) li++;
            if (regWr) obs.push_back('{Rw, busW});
            if (obs.size() >= 10 && li == 6) break;
        end
        clr_inputs();
        chk("wrap_count", obs.size(), 10);
        if (obs.size() == 10) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("wrap_alu%0d_Rw", j), {27'd0, obs[j].rw}, 4);
                chk($sformatf("wrap_alu%0d_busW", j), obs[j].data, 32'h400 + j);
            end
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("wrap_ld%0d_Rw", j), {27'd0, obs[4+j].rw}, 10 + j);
                chk($sformatf("wrap_ld%0d_busW", j), obs[4+j].data, 32'hA0 + j);
            end
        end
        chk("wrap_pending_clr", pending, 0);
        tick();

        // destination 0 from issue and load side
        issue(5'd0);
        chk("dst0_pending", pending, 0);
        issue(5'd20);
        ld_valid = 1; ld_Rw = 0; ld_data = 32'h77;
        tick();
        chk("dst0_enq_regWr", {31'd0, regWr}, 0);
        ld_Rw = 20; ld_data = 32'h20;
        tick();
        ld_valid = 0;
        chk("dst0_pop_regWr", {31'd0, regWr}, 0);
        tick();
        chk("dst0_next_Rw", {27'd0, Rw, regWr}, {27'd20, 1'b1});
        chk("dst0_next_busW", busW, 32'h20);
        chk("dst0_next_pending", pending, 0);
        clr_inputs();
        tick();

        // asynchronous reset mid-cycle with pending bits and a full FIFO
        issue(5'd21);
        issue(5'd22);
        alu_valid = 1; alu_Rdst = 1; alu_Rd = 4; alu_data = 32'h55AA;
        ld_valid = 1; ld_Rw = 21; ld_data = 32'h21;
        tick();
        ld_Rw = 22; ld_data = 32'h22;
        tick();
        ld_valid = 0;
        hz_Rs = 21;
        #1;
        chk("pre_rst_full", {31'd0, ld_ready}, 0);
        chk("pre_rst_pending", pending, 32'h0060_0000);
        chk("pre_rst_regWr", {27'd0, Rw, regWr}, {27'd4, 1'b1});
        #2 reset_n = 0;
        #1;
        chk("arst_regWr", {31'd0, regWr}, 0);
        chk("arst_Rw", {27'd0, Rw}, 0);
        chk("arst_busW", busW, 0);
        chk("arst_pending", pending, 0);
        chk("arst_hazard", {31'd0, hazard}, 0);
        chk("arst_ld_ready", {31'd0, ld_ready}, 0);
        clr_inputs();
        @(posedge clk);
        #3 reset_n = 1;
        #1 chk("arst_rel_ld_ready", {31'd0, ld_ready}, 1);
        tick();
        chk("arst_discard0", {31'd0, regWr}, 0);
        tick();
        chk("arst_discard1", {31'd0, regWr}, 0);
        chk("arst_discard_ready", {31'd0, ld_ready}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
